// File: rtl/neuron_accum.sv
// rtl/neuron_accum.sv - accumulates NUM_CHUNKS signed 8.18 partials per neuron, adds bias,
// applies a clamping ReLU and presents one result per neuron with a wrapping index.
module neuron_accum #(
  parameter int NUM_CHUNKS  = 8,
  parameter int NUM_NEURONS = 10,
  parameter int ACC_W       = 30,
  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
  input  logic             clk,
  input  logic             GlobalReset,
  input  logic [25:0]      in_value,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [25:0]      bias_in,
  output logic [25:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  typedef enum logic [1:0] {ACCUM, FINISH, OUTPUT} state_t;

  // Largest positive 8.18 value, widened to the accumulator for the clamp compare.
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-25){1'b0}}, 25'h1FFFFFF};
  localparam logic [CNT_W-1:0] LAST_CHUNK  = CNT_W'(NUM_CHUNKS - 1);
  localparam logic [IDX_W-1:0] LAST_NEURON = IDX_W'(NUM_NEURONS - 1);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic        [25:0]      bias_reg;
  logic        [CNT_W-1:0] chunk_cnt;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] sum;

  assign in_ext   = {{(ACC_W-26){in_value[25]}}, in_value};
  assign bias_ext = {{(ACC_W-26){bias_reg[25]}}, bias_reg};
  assign sum      = acc + bias_ext;

  assign in_ready = (state == ACCUM);
  assign out_last = out_valid && (out_idx == LAST_NEURON);

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state     <= ACCUM;
      acc       <= '0;
      bias_reg  <= '0;
      chunk_cnt <= '0;
      out_idx   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid && in_ready) begin
            // The first chunk reloads acc so nothing from the previous neuron survives.
            if (chunk_cnt == '0) begin
              acc      <= in_ext;
              bias_reg <= bias_in;
            end else begin
              acc <= acc + in_ext;
            end
            if (chunk_cnt == LAST_CHUNK) begin
              chunk_cnt <= '0;
              state     <= FINISH;
            end else begin
              chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
          end
        end
        FINISH: begin
          if (sum < 0)
            out_data <= '0;
          else if (sum > SAT_MAX)
            out_data <= 26'h1FFFFFF;
          else
            out_data <= sum[25:0];
          out_valid <= 1'b1;
          state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
            out_idx   <= (out_idx == LAST_NEURON) ? '0 : out_idx + IDX_W'(1);
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accum.sv
// tb/tb_neuron_accum.sv - scoreboard bench for neuron_accum: directed neurons are queued with
// hand-computed results and a negedge monitor checks every presented output.
module tb_neuron_accum;

  localparam int NC = 8;
  localparam int NN = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [25:0]   in_value;
  logic          in_valid;
  logic          in_ready;
  logic [25:0]   bias_in;
  logic [25:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;

  neuron_accum #(.NUM_CHUNKS(NC), .NUM_NEURONS(NN), .ACC_W(30)) dut (
    .clk(clk), .GlobalReset(rst),
    .in_value(in_value), .in_valid(in_valid), .in_ready(in_ready),
    .bias_in(bias_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0]   data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   xfer_cnt = 0;
  int   last_chunk_edge = 0;
  int   last_xfer_edge = 0;
  int   hs_edge = 0;
  int   first_xfer_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: samples on the falling edge, so values are those the next rising edge will see.
  logic          pv, phs, pl;
  logic [25:0]   pd;
  logic [IW-1:0] pi;
  always @(negedge clk) begin
    if (rst) begin
      xfer_cnt = 0;
      pv = 1'b0;
      phs = 1'b0;
    end else begin
      if (pv && !phs)
        check("hold_stable", {out_valid, out_last, out_idx, out_data}, {1'b1, pl, pi, pd});
      if (out_valid)
        check("in_ready_blocked", in_ready, 0);
      if (out_valid && !pv)
        check("latency", cyc + 1 - last_chunk_edge, 2);
      if (in_valid && in_ready) begin
        xfer_cnt++;
        last_xfer_edge = cyc + 1;
        if (xfer_cnt % NC == 0) last_chunk_edge = cyc + 1;
      end
      if (out_valid && out_ready) begin
        hs_edge = cyc + 1;
        if (sbq.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("out_data", out_data, e.data);
          check("out_idx_last", {out_idx, out_last}, {e.idx, e.last});
        end
      end
      pv  = out_valid;
      phs = out_valid && out_ready;
      pd  = out_data;
      pi  = out_idx;
      pl  = out_last;
    end
  end

  task automatic send_chunk(input logic [25:0] v, input logic [25:0] b, input int gap);
    int t;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    in_value = v;
    bias_in  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Seven chunks of a, then lastv; bias is only meaningful on the first chunk.
  task automatic send_neuron(input logic [25:0] a, input logic [25:0] lastv, input logic [25:0] b,
                             input logic [25:0] exp_data, input int exp_idx, input int maxgap);
    exp_t e;
    e.data = exp_data;
    e.idx  = IW'(exp_idx);
    e.last = (exp_idx == NN - 1);
    sbq.push_back(e);
    for (int i = 0; i < NC; i++) begin
      send_chunk((i == NC - 1) ? lastv : a, (i == 0) ? b : 26'($urandom),
                 (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      if (i == 0) first_xfer_edge = last_xfer_edge;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() > 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (sbq.size() > 0) check("drain_timeout", sbq.size(), 0);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("reset_state", {in_ready, out_valid, out_last, out_idx, out_data}, 64'h1 << (3 + IW + 26 - 1));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_value  = '0;
    in_valid  = 1'b0;
    bias_in   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, out_last, out_idx, out_data}, 64'h1 << (3 + IW + 26 - 1));
    rst = 1'b0;

    send_neuron(26'h0040000, 26'h0040000, 26'h0020000, 26'h0220000, 0, 0);
    send_neuron(26'h3FC0000, 26'h3FC0000, 26'h0000000, 26'h0000000, 1, 0);
    send_neuron(26'h0040000, 26'h3FC0000, 26'h3E60000, 26'h0000000, 2, 0);
    send_neuron(26'h1FFFFFF, 26'h1FFFFFF, 26'h1FFFFFF, 26'h1FFFFFF, 3, 0);
    drain();

    out_ready = 1'b0;
    fork
      begin
        send_neuron(26'h0080000, 26'h0080000, 26'h0000000, 26'h0400000, 4, 0);
        send_neuron(26'h0040000, 26'h0040000, 26'h0000000, 26'h0200000, 5, 0);
      end
      begin
        int t;
        t = 0;
        while (!out_valid && t < 200) begin
          @(posedge clk);
          #1;
          t++;
        end
        check("bp_out_valid_seen", out_valid, 1);
        repeat (5) begin
          @(posedge clk);
          #1;
          check("bp_in_ready", {in_valid, in_ready}, 2'b10);
        end
        out_ready = 1'b1;
      end
    join
    check("first_after_handshake", first_xfer_edge - hs_edge, 1);
    drain();

    for (int i = 0; i < 3; i++) send_chunk(26'h0040000, 26'h0000000, 0);
    do_reset();
    send_neuron(26'h0040000, 26'h0040000, 26'h0000000, 26'h0200000, 0, 0);
    drain();

    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int k = 0; k <= NN; k++)
        send_neuron(26'h0040000, 26'h0040000, 26'(k * 32'h10000), 26'(32'h200000 + k * 32'h10000),
                    k % NN, pass * 3);
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
